// File: rtl/alu_res_station_array.sv
// ALU reservation station array: operand storage, CDB wakeup and
// lowest-index dispatch to the ALU over a valid/ready handshake.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   RS_ld_busy            per-station strobe: mark busy, load op and dest tag
//   RS_issue_ld_V[jk]     per-station strobe: load operand value (ready)
//   RS_issue_ld_Q[jk]     per-station strobe: load operand tag (pending)
//   issue_*               shared issue operand bus
//   cdb_valid/tag/data    common data bus broadcast
//   flush                 synchronous squash of every entry
//   alu_valid/alu_ready   dispatch handshake
//   alu_*                 selected entry contents
//   rs_busy               registered busy bits

package lc3b_types;
    typedef logic [15:0] lc3b_word;
    typedef enum logic [3:0] {
        alu_add  = 4'd0,
        alu_and  = 4'd1,
        alu_not  = 4'd2,
        alu_pass = 4'd3,
        alu_sll  = 4'd4,
        alu_srl  = 4'd5,
        alu_sra  = 4'd6
    } lc3b_aluop;
endpackage

module alu_res_station_array
    import lc3b_types::*;
#(
    parameter int NUM_RS = 3,
    parameter int TAG_W  = 3,
    localparam int ID_W  = (NUM_RS > 1) ? $clog2(NUM_RS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_RS-1:0] RS_ld_busy,
    input  logic [NUM_RS-1:0] RS_issue_ld_Vj,
    input  logic [NUM_RS-1:0] RS_issue_ld_Vk,
    input  logic [NUM_RS-1:0] RS_issue_ld_Qj,
    input  logic [NUM_RS-1:0] RS_issue_ld_Qk,
    input  lc3b_word          issue_Vj,
    input  lc3b_word          issue_Vk,
    input  logic [TAG_W-1:0]  issue_Qj,
    input  logic [TAG_W-1:0]  issue_Qk,
    input  lc3b_aluop         issue_aluop,
    input  logic [TAG_W-1:0]  issue_dest_tag,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  lc3b_word          cdb_data,
    input  logic              flush,
    output logic              alu_valid,
    input  logic              alu_ready,
    output lc3b_word          alu_Vj,
    output lc3b_word          alu_Vk,
    output lc3b_aluop         alu_aluop,
    output logic [TAG_W-1:0]  alu_dest_tag,
    output logic [ID_W-1:0]   alu_rs_id,
    output logic [NUM_RS-1:0] rs_busy
);

    logic [NUM_RS-1:0] busy_q, busy_d;
    logic [NUM_RS-1:0] j_rdy_q, j_rdy_d;
    logic [NUM_RS-1:0] k_rdy_q, k_rdy_d;
    lc3b_aluop         aluop_q [NUM_RS];
    lc3b_aluop         aluop_d [NUM_RS];
    logic [TAG_W-1:0]  dest_q  [NUM_RS];
    logic [TAG_W-1:0]  dest_d  [NUM_RS];
    lc3b_word          vj_q    [NUM_RS];
    lc3b_word          vj_d    [NUM_RS];
    lc3b_word          vk_q    [NUM_RS];
    lc3b_word          vk_d    [NUM_RS];
    logic [TAG_W-1:0]  qj_q    [NUM_RS];
    logic [TAG_W-1:0]  qj_d    [NUM_RS];
    logic [TAG_W-1:0]  qk_q    [NUM_RS];
    logic [TAG_W-1:0]  qk_d    [NUM_RS];

    logic [NUM_RS-1:0] ready;
    logic [ID_W-1:0]   sel_id;
    logic              sel_vld;
    logic              dispatch;
    logic              byp_j;
    logic              byp_k;

    assign rs_busy  = busy_q;
    assign ready    = busy_q & j_rdy_q & k_rdy_q;
    assign dispatch = sel_vld & alu_ready;

    // Issue-cycle CDB match on the incoming tags avoids a lost wakeup.
    assign byp_j = cdb_valid && (cdb_tag == issue_Qj);
    assign byp_k = cdb_valid && (cdb_tag == issue_Qk);

    // Scan downward so the lowest ready index is the last one written.
    always_comb begin
        sel_id  = '0;
        sel_vld = 1'b0;
        for (int i = NUM_RS - 1; i >= 0; i--) begin
            if (ready[i]) begin
                sel_id  = ID_W'(i);
                sel_vld = 1'b1;
            end
        end
    end

    always_comb begin
        alu_valid    = sel_vld;
        alu_rs_id    = sel_id;
        alu_Vj       = '0;
        alu_Vk       = '0;
        alu_aluop    = alu_add;
        alu_dest_tag = '0;
        if (sel_vld) begin
            alu_Vj       = vj_q[sel_id];
            alu_Vk       = vk_q[sel_id];
            alu_aluop    = aluop_q[sel_id];
            alu_dest_tag = dest_q[sel_id];
        end
    end

    always_comb begin
        busy_d  = busy_q;
        j_rdy_d = j_rdy_q;
        k_rdy_d = k_rdy_q;
        for (int i = 0; i < NUM_RS; i++) begin
            aluop_d[i] = aluop_q[i];
            dest_d[i]  = dest_q[i];
            vj_d[i]    = vj_q[i];
            vk_d[i]    = vk_q[i];
            qj_d[i]    = qj_q[i];
            qk_d[i]    = qk_q[i];

            // Wakeup of pending operands in resident entries.
            if (busy_q[i] && !j_rdy_q[i] && cdb_valid &&
                cdb_tag == qj_q[i]) begin
                vj_d[i]    = cdb_data;
                j_rdy_d[i] = 1'b1;
            end
            if (busy_q[i] && !k_rdy_q[i] && cdb_valid &&
                cdb_tag == qk_q[i]) begin
                vk_d[i]    = cdb_data;
                k_rdy_d[i] = 1'b1;
            end

            if (dispatch && sel_id == ID_W'(i)) begin
                busy_d[i] = 1'b0;
            end

            // Issue after dispatch: a reload of the leaving entry wins.
            if (RS_ld_busy[i]) begin
                busy_d[i]  = 1'b1;
                aluop_d[i] = issue_aluop;
                dest_d[i]  = issue_dest_tag;
            end

            if (RS_issue_ld_Vj[i]) begin
                vj_d[i]    = issue_Vj;
                j_rdy_d[i] = 1'b1;
            end else if (RS_issue_ld_Qj[i]) begin
                qj_d[i] = issue_Qj;
                if (byp_j) begin
                    vj_d[i]    = cdb_data;
                    j_rdy_d[i] = 1'b1;
                end else begin
                    j_rdy_d[i] = 1'b0;
                end
            end

            if (RS_issue_ld_Vk[i]) begin
                vk_d[i]    = issue_Vk;
                k_rdy_d[i] = 1'b1;
            end else if (RS_issue_ld_Qk[i]) begin
                qk_d[i] = issue_Qk;
                if (byp_k) begin
                    vk_d[i]    = cdb_data;
                    k_rdy_d[i] = 1'b1;
                end else begin
                    k_rdy_d[i] = 1'b0;
                end
            end
        end

        if (flush) begin
            busy_d  = '0;
            j_rdy_d = '0;
            k_rdy_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q  <= '0;
            j_rdy_q <= '0;
            k_rdy_q <= '0;
        end else begin
            busy_q  <= busy_d;
            j_rdy_q <= j_rdy_d;
            k_rdy_q <= k_rdy_d;
        end
    end

    // Payload fields need no reset; they are qualified by busy/ready.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_RS; i++) begin
            aluop_q[i] <= aluop_d[i];
            dest_q[i]  <= dest_d[i];
            vj_q[i]    <= vj_d[i];
            vk_q[i]    <= vk_d[i];
            qj_q[i]    <= qj_d[i];
            qk_q[i]    <= qk_d[i];
        end
    end

endmodule
